player_bullet: RTL

- Producer side of the bullet interface that the `alien` block consumes.
- Launches one player bullet from the ship on a fire press and moves it up the screen once per frame.
- Retires the bullet at the top of the screen or when an alien reports `alien_hit`, then enforces a frame-based cooldown.
- Drives `bullet_x`, `bullet_y` and `bullet_active` to every alien instance, and provides a pixel/active overlay to the video mixer.

---
 rtl/gatorga_pkg.sv | 15 +
 rtl/btn_sync_edge.sv | 30 +++
 rtl/player_bullet.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/gatorga_pkg.sv
// Shared screen constants and types for the gatorga sprite blocks.
package gatorga_pkg;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef logic [0:2][7:0]     rgb_t;    // [0]=R, [1]=G, [2]=B
    typedef logic signed [11:0]  coord_t;
    typedef logic signed [12:0]  coord13_t;

    typedef enum logic [1:0] {IDLE, FLY, COOLDOWN} bullet_state_e;

    function automatic coord13_t ext13(input coord_t c);
        return {c[11], c};
    endfunction
endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous button plus a rising-edge pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);
    logic sync1_q, sync2_q, prev_q;
    logic sync1_d, sync2_d, prev_d;

    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign rise = sync2_q & ~prev_q;
endmodule

// File: rtl/player_bullet.sv
// Player bullet: launch on fire at frame start, climb once per frame, retire
// on hit or top of screen, then hold off relaunch for a frame cooldown.
module player_bullet
    import gatorga_pkg::*;
#(
    parameter int BULLET_W        = 2,
    parameter int BULLET_H        = 8,
    parameter int SPEED           = 6,
    parameter int SHIP_Y          = 440,
    parameter int SHIP_XOFF       = 7,
    parameter int TOP_Y           = 0,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic   pixel_clk,
    input  logic   rst,
    input  logic   fsync,
    input  coord_t hpos,
    input  coord_t vpos,
    input  coord_t ship_x,
    input  logic   fire_btn,
    input  logic   alien_hit,
    output coord_t bullet_x,
    output coord_t bullet_y,
    output logic   bullet_active,
    output rgb_t   pixel,
    output logic   active
);
    localparam int CD_W = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [CD_W-1:0] CD_INIT = CD_W'(COOLDOWN_FRAMES);
    localparam coord13_t W13     = coord13_t'(BULLET_W);
    localparam coord13_t H13     = coord13_t'(BULLET_H);
    localparam coord13_t SPEED13 = coord13_t'(SPEED);
    localparam coord13_t XOFF13  = coord13_t'(SHIP_XOFF);
    localparam coord13_t TOP13   = coord13_t'(TOP_Y);
    localparam coord13_t SPAWN13 = coord13_t'(SHIP_Y) - coord13_t'(BULLET_H);
    localparam rgb_t     BULLET_RGB = {8'hFF, 8'hFF, 8'h00};

    bullet_state_e   state_q, state_d;
    logic            fire_pend_q, fire_pend_d;
    logic [CD_W-1:0] cd_q, cd_d;
    coord_t          bx_q, bx_d, by_q, by_d;
    logic            bact_q, bact_d;
    logic            act_q, act_d;
    rgb_t            pix_q, pix_d;

    logic     fire_rise;
    coord13_t ny, launch_x;
    coord13_t hx, vy, bx13, by13;
    logic     hit;

    btn_sync_edge u_fire (
        .clk  (pixel_clk),
        .rst  (rst),
        .btn  (fire_btn),
        .rise (fire_rise)
    );

    always_comb begin
        state_d     = state_q;
        fire_pend_d = fire_pend_q;
        cd_d        = cd_q;
        bx_d        = bx_q;
        by_d        = by_q;
        bact_d      = bact_q;
        ny          = ext13(by_q) - SPEED13;
        launch_x    = ext13(ship_x) + XOFF13;

        unique case (state_q)
            IDLE: begin
                // An edge coinciding with fsync only latches; launch waits a frame.
                fire_pend_d = fire_pend_q | fire_rise;
                if (fsync && fire_pend_q) begin
                    bx_d        = coord_t'(launch_x);
                    by_d        = coord_t'(SPAWN13);
                    bact_d      = 1'b1;
                    fire_pend_d = 1'b0;
                    state_d     = FLY;
                end
            end
            FLY: begin
                fire_pend_d = 1'b0;
                if (alien_hit) begin
                    bact_d  = 1'b0;
                    cd_d    = CD_INIT;
                    state_d = COOLDOWN;
                end else if (fsync) begin
                    if (ny < TOP13) begin
                        bact_d  = 1'b0;
                        cd_d    = CD_INIT;
                        state_d = COOLDOWN;
                    end else begin
                        by_d = coord_t'(ny);
                    end
                end
            end
            COOLDOWN: begin
                fire_pend_d = 1'b0;
                if (fsync) begin
                    if (cd_q <= CD_W'(1)) begin
                        cd_d    = '0;
                        state_d = IDLE;
                    end else begin
                        cd_d = cd_q - CD_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hx    = ext13(hpos);
        vy    = ext13(vpos);
        bx13  = ext13(bx_q);
        by13  = ext13(by_q);
        hit   = bact_q && (hx >= bx13) && (hx < bx13 + W13)
                       && (vy >= by13) && (vy < by13 + H13);
        act_d = hit;
        pix_d = hit ? BULLET_RGB : '0;
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fire_pend_q <= 1'b0;
            cd_q        <= '0;
            bx_q        <= '0;
            by_q        <= '0;
            bact_q      <= 1'b0;
            act_q       <= 1'b0;
            pix_q       <= '0;
        end else begin
            state_q     <= state_d;
            fire_pend_q <= fire_pend_d;
            cd_q        <= cd_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            bact_q      <= bact_d;
            act_q       <= act_d;
            pix_q       <= pix_d;
        end
    end

    assign bullet_x      = bx_q;
    assign bullet_y      = by_q;
    assign bullet_active = bact_q;
    assign pixel         = pix_q;
    assign active        = act_q;
endmodule
